// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges NCH sram-like masters onto one sram-like memory port.
// Requests are granted by fixed or round-robin priority; the owner of every accepted
// request is pushed into an ID FIFO so in-order responses are routed back to it.
module sram_like_arbiter #(
    parameter int unsigned NCH     = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned RR      = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    // CPU-side masters
    input  logic [NCH-1:0]        s_req,
    input  logic [NCH-1:0]        s_wr,
    input  logic [2*NCH-1:0]      s_size,
    input  logic [NCH*DW/8-1:0]   s_wstrb,
    input  logic [NCH*AW-1:0]     s_addr,
    input  logic [NCH*DW-1:0]     s_wdata,
    output logic [NCH-1:0]        s_addr_ok,
    output logic [NCH-1:0]        s_data_ok,
    output logic [DW-1:0]         s_rdata,
    // Memory-side port
    output logic                  m_req,
    output logic                  m_wr,
    output logic [1:0]            m_size,
    output logic [DW/8-1:0]       m_wstrb,
    output logic [AW-1:0]         m_addr,
    output logic [DW-1:0]         m_wdata,
    input  logic                  m_addr_ok,
    input  logic                  m_data_ok,
    input  logic [DW-1:0]         m_rdata,
    // Status
    output logic                  busy,
    output logic                  err_unexp
);

    localparam int unsigned IDW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CW  = $clog2(MAX_OUT + 1);
    localparam int unsigned SW  = DW / 8;

    // Per-channel views of the flattened request buses
    logic [1:0]    size_arr  [NCH];
    logic [SW-1:0] wstrb_arr [NCH];
    logic [AW-1:0] addr_arr  [NCH];
    logic [DW-1:0] wdata_arr [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_unpack
        assign size_arr[g]  = s_size[g*2 +: 2];
        assign wstrb_arr[g] = s_wstrb[g*SW +: SW];
        assign addr_arr[g]  = s_addr[g*AW +: AW];
        assign wdata_arr[g] = s_wdata[g*DW +: DW];
    end

    // State
    logic           lock_v_q, lock_v_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] fifo_q [MAX_OUT];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           err_q, err_d;

    logic           grant_v;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] head;
    logic           full;
    logic           accept;
    logic           resp;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Grant selection: a held lock wins, otherwise fixed or round-robin priority
    always_comb begin
        grant_v  = 1'b0;
        grant_id = '0;
        cand     = '0;
        if (lock_v_q) begin
            grant_v  = 1'b1;
            grant_id = lock_id_q;
        end else if (RR == 0) begin
            for (int i = 0; i < int'(NCH); i++) begin
                if (s_req[i]) begin
                    grant_v  = 1'b1;
                    grant_id = IDW'(i);
                end
            end
        end else begin
            // Scan farthest-first so the channel closest after rr_ptr is assigned last
            for (int k = int'(NCH); k >= 1; k--) begin
                cand = IDW'((32'(rr_ptr_q) + 32'(k)) % NCH);
                if (s_req[cand]) begin
                    grant_v  = 1'b1;
                    grant_id = cand;
                end
            end
        end
    end

    assign full   = (count_q == CW'(MAX_OUT));
    assign head   = fifo_q[rd_ptr_q];
    assign accept = m_req & m_addr_ok;
    assign resp   = resetn & m_data_ok & (count_q != '0);

    // Downstream request fields come straight from the granted channel
    always_comb begin
        m_req     = resetn & grant_v & ~full;
        m_wr      = s_wr[grant_id];
        m_size    = size_arr[grant_id];
        m_wstrb   = wstrb_arr[grant_id];
        m_addr    = addr_arr[grant_id];
        m_wdata   = wdata_arr[grant_id];
        s_addr_ok = accept ? (NCH'(1) << grant_id) : '0;
        s_data_ok = resp ? (NCH'(1) << head) : '0;
        s_rdata   = m_rdata;
        busy      = (count_q != '0);
        err_unexp = err_q;
    end

    // Next-state for lock, round-robin pointer, FIFO bookkeeping and error flag
    always_comb begin
        lock_v_d  = lock_v_q;
        lock_id_d = lock_id_q;
        rr_ptr_d  = rr_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_d     = err_q | (m_data_ok & (count_q == '0));

        if (accept) begin
            lock_v_d = 1'b0;
            wr_ptr_d = ptr_inc(wr_ptr_q);
            if (RR != 0) begin
                rr_ptr_d = grant_id;
            end
        end else if (m_req) begin
            // Stalled request: freeze the grant so downstream fields stay stable
            lock_v_d  = 1'b1;
            lock_id_d = grant_id;
        end

        if (resp) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({accept, resp})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards everything in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_v_q  <= 1'b0;
            lock_id_q <= '0;
            rr_ptr_q  <= IDW'(NCH - 1);
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < int'(MAX_OUT); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            lock_v_q  <= lock_v_d;
            lock_id_q <= lock_id_d;
            rr_ptr_q  <= rr_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
            if (accept) begin
                fifo_q[wr_ptr_q] <= grant_id;
            end
        end
    end

endmodule
